// File: rtl/turn_controller_if.sv
// Signal bundle between turn_controller, the two players and GameState.
// master = the controller, slave = players/GameState side.
interface turn_controller_if;
    logic       new_game;
    logic       x_req;
    logic [3:0] x_pos;
    logic       o_req;
    logic [3:0] o_pos;
    logic [2:0] gs_status;
    logic       gs_rst;
    logic       gs_move;
    logic       gs_player;
    logic [3:0] gs_next_move;
    logic       turn;
    logic       busy;
    logic       move_ack;
    logic       move_nack;
    logic       timeout;
    logic       game_over;
    logic [1:0] winner;
    logic [3:0] move_count;

    modport master (
        input  new_game, x_req, x_pos, o_req, o_pos, gs_status,
        output gs_rst, gs_move, gs_player, gs_next_move, turn, busy,
               move_ack, move_nack, timeout, game_over, winner, move_count
    );

    modport slave (
        output new_game, x_req, x_pos, o_req, o_pos, gs_status,
        input  gs_rst, gs_move, gs_player, gs_next_move, turn, busy,
               move_ack, move_nack, timeout, game_over, winner, move_count
    );
endinterface

// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencer: filters player requests, issues one-cycle
// move commands to GameState, evaluates GameStatus, tracks game over,
// new-game restarts and an optional per-turn timeout. All outputs registered.
module turn_controller #(
    parameter bit          FIRST_PLAYER = 1'b1,
    parameter int unsigned RESP_LAT     = 2,
    parameter int unsigned TURN_TIMEOUT = 0
) (
    input logic              clk,
    input logic              rst,
    turn_controller_if.master bus
);

    typedef enum logic [2:0] {
        GAME_RST,
        WAIT_REQ,
        ISSUE,
        WAIT_RESP,
        EVAL,
        OVER
    } state_t;

    localparam logic [3:0]  LAT_LAST = 4'(RESP_LAT);
    localparam logic [23:0] TO_LAST  = (TURN_TIMEOUT > 0) ? 24'(TURN_TIMEOUT - 1) : '0;

    state_t      state, state_nxt;
    logic        gs_rst_q, gs_rst_nxt;
    logic        gs_move_q, gs_move_nxt;
    logic        gs_player_q, gs_player_nxt;
    logic [3:0]  gs_next_move_q, gs_next_move_nxt;
    logic        turn_q, turn_nxt;
    logic        busy_q, busy_nxt;
    logic        move_ack_q, move_ack_nxt;
    logic        move_nack_q, move_nack_nxt;
    logic        timeout_q, timeout_nxt;
    logic        game_over_q, game_over_nxt;
    logic [1:0]  winner_q, winner_nxt;
    logic [3:0]  move_count_q, move_count_nxt;
    logic [3:0]  lat_cnt_q, lat_cnt_nxt;
    logic [23:0] to_cnt_q, to_cnt_nxt;

    logic        req_hit;
    logic [3:0]  req_pos;
    logic [3:0]  count_inc;

    // State register and all registered outputs/counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= GAME_RST;
            gs_rst_q       <= 1'b1;
            gs_move_q      <= 1'b0;
            gs_player_q    <= FIRST_PLAYER;
            gs_next_move_q <= '0;
            turn_q         <= FIRST_PLAYER;
            busy_q         <= 1'b1;
            move_ack_q     <= 1'b0;
            move_nack_q    <= 1'b0;
            timeout_q      <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= '0;
            move_count_q   <= '0;
            lat_cnt_q      <= '0;
            to_cnt_q       <= '0;
        end else begin
            state          <= state_nxt;
            gs_rst_q       <= gs_rst_nxt;
            gs_move_q      <= gs_move_nxt;
            gs_player_q    <= gs_player_nxt;
            gs_next_move_q <= gs_next_move_nxt;
            turn_q         <= turn_nxt;
            busy_q         <= busy_nxt;
            move_ack_q     <= move_ack_nxt;
            move_nack_q    <= move_nack_nxt;
            timeout_q      <= timeout_nxt;
            game_over_q    <= game_over_nxt;
            winner_q       <= winner_nxt;
            move_count_q   <= move_count_nxt;
            lat_cnt_q      <= lat_cnt_nxt;
            to_cnt_q       <= to_cnt_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt        = state;
        gs_player_nxt    = gs_player_q;
        gs_next_move_nxt = gs_next_move_q;
        turn_nxt         = turn_q;
        winner_nxt       = winner_q;
        move_count_nxt   = move_count_q;
        lat_cnt_nxt      = lat_cnt_q;
        to_cnt_nxt       = '0;
        move_ack_nxt     = 1'b0;
        move_nack_nxt    = 1'b0;
        timeout_nxt      = 1'b0;

        req_hit   = turn_q ? bus.x_req : bus.o_req;
        req_pos   = turn_q ? bus.x_pos : bus.o_pos;
        count_inc = (move_count_q < 4'd9) ? move_count_q + 4'd1 : move_count_q;

        if (bus.new_game) begin
            state_nxt = GAME_RST;
        end else begin
            case (state)
                GAME_RST: state_nxt = WAIT_REQ;

                WAIT_REQ: begin
                    if (req_hit) begin
                        if (req_pos <= 4'd8) begin
                            gs_next_move_nxt = req_pos;
                            gs_player_nxt    = turn_q;
                            lat_cnt_nxt      = 4'd1;
                            state_nxt        = ISSUE;
                        end else begin
                            move_nack_nxt = 1'b1;
                        end
                    end else if (TURN_TIMEOUT != 0) begin
                        if (to_cnt_q == TO_LAST) begin
                            turn_nxt    = ~turn_q;
                            timeout_nxt = 1'b1;
                        end else begin
                            to_cnt_nxt = to_cnt_q + 24'd1;
                        end
                    end
                end

                // ISSUE is the first latency cycle; with RESP_LAT = 1 the
                // status is already valid in the following cycle.
                ISSUE: begin
                    lat_cnt_nxt = lat_cnt_q + 4'd1;
                    state_nxt   = (RESP_LAT <= 1) ? EVAL : WAIT_RESP;
                end

                WAIT_RESP: begin
                    if (lat_cnt_q >= LAT_LAST) begin
                        state_nxt = EVAL;
                    end else begin
                        lat_cnt_nxt = lat_cnt_q + 4'd1;
                    end
                end

                EVAL: begin
                    if (bus.gs_status[2]) begin
                        move_nack_nxt = 1'b1;
                        state_nxt     = WAIT_REQ;
                    end else begin
                        move_ack_nxt   = 1'b1;
                        move_count_nxt = count_inc;
                        if (bus.gs_status[1:0] == 2'd0) begin
                            turn_nxt = ~turn_q;
                            if (count_inc == 4'd9) begin
                                winner_nxt = 2'd3;
                                state_nxt  = OVER;
                            end else begin
                                state_nxt = WAIT_REQ;
                            end
                        end else begin
                            winner_nxt = bus.gs_status[1:0];
                            state_nxt  = OVER;
                        end
                    end
                end

                OVER: state_nxt = OVER;

                default: state_nxt = GAME_RST;
            endcase
        end

        if (state_nxt == GAME_RST) begin
            turn_nxt       = FIRST_PLAYER;
            move_count_nxt = '0;
            winner_nxt     = '0;
        end

        gs_rst_nxt    = (state_nxt == GAME_RST);
        gs_move_nxt   = (state_nxt == ISSUE);
        game_over_nxt = (state_nxt == OVER);
        busy_nxt      = (state_nxt == GAME_RST) || (state_nxt == ISSUE) ||
                        (state_nxt == WAIT_RESP) || (state_nxt == EVAL);
    end

    assign bus.gs_rst       = gs_rst_q;
    assign bus.gs_move      = gs_move_q;
    assign bus.gs_player    = gs_player_q;
    assign bus.gs_next_move = gs_next_move_q;
    assign bus.turn         = turn_q;
    assign bus.busy         = busy_q;
    assign bus.move_ack     = move_ack_q;
    assign bus.move_nack    = move_nack_q;
    assign bus.timeout      = timeout_q;
    assign bus.game_over    = game_over_q;
    assign bus.winner       = winner_q;
    assign bus.move_count   = move_count_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: one instance without timeout for
// game flow, one with TURN_TIMEOUT = 10 for forfeit and abort behaviour.
module tb_turn_controller;

    localparam int RESP_LAT = 2;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    turn_controller_if ia ();
    turn_controller_if ib ();

    turn_controller #(
        .FIRST_PLAYER (1'b1),
        .RESP_LAT     (RESP_LAT),
        .TURN_TIMEOUT (0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.master)
    );

    turn_controller #(
        .FIRST_PLAYER (1'b1),
        .RESP_LAT     (RESP_LAT),
        .TURN_TIMEOUT (10)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Drives one request on instance A from the current negedge and acts as
    // GameState: status is valid only in the cycle RESP_LAT after gs_move.
    task automatic do_move(input bit is_x, input logic [3:0] pos, input logic [2:0] status,
                           input bit both, output int n_move, output int ack_at,
                           output int nack_at, output logic mv_player, output logic [3:0] mv_pos);
        n_move = 0; ack_at = -1; nack_at = -1; mv_player = 1'b0; mv_pos = '0;
        if (is_x || both) begin ia.x_req = 1'b1; ia.x_pos = is_x ? pos : 4'd5; end
        if (!is_x || both) begin ia.o_req = 1'b1; ia.o_pos = is_x ? 4'd5 : pos; end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ia.x_req = 1'b0;
            ia.o_req = 1'b0;
            ia.gs_status = (c == RESP_LAT + 1) ? status : 3'd4;
            if (ia.gs_move) begin
                n_move++;
                mv_player = ia.gs_player;
                mv_pos    = ia.gs_next_move;
            end
            if (ia.move_ack && ack_at < 0) ack_at = c;
            if (ia.move_nack && nack_at < 0) nack_at = c;
        end
        ia.gs_status = 3'd4;
    endtask

    initial begin : main
        int         nm, ack, nack, tot_m, tot_a, first_to, n_to, n_ack_b;
        logic       pl;
        logic [3:0] ps;

        rst = 1'b0;
        ia.new_game = 0; ia.x_req = 0; ia.x_pos = '0; ia.o_req = 0; ia.o_pos = '0;
        ia.gs_status = 3'd4;
        ib.new_game = 0; ib.x_req = 0; ib.x_pos = '0; ib.o_req = 0; ib.o_pos = '0;
        ib.gs_status = 3'd0;

        repeat (3) @(negedge clk);
        check("rst_gs_rst", ia.gs_rst, 1);
        check("rst_turn", ia.turn, 1);
        check("rst_move_count", ia.move_count, 0);
        check("rst_gs_move", ia.gs_move, 0);
        check("rst_game_over", ia.game_over, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_gs_rst_low", ia.gs_rst, 0);
        @(negedge clk);
        check("rel_busy_low", ia.busy, 0);
        check("rel_turn", ia.turn, 1);

        // X to cell 0, running
        do_move(1'b1, 4'd0, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("x0_gs_move_cnt", nm, 1);
        check("x0_player", pl, 1);
        check("x0_pos", ps, 0);
        check("x0_ack_lat", ack, RESP_LAT + 2);
        check("x0_no_nack", nack, -1);
        check("x0_turn", ia.turn, 0);
        check("x0_count", ia.move_count, 1);

        // O out of range, then X out of turn
        do_move(1'b0, 4'd9, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("o9_nack_lat", nack, 1);
        check("o9_no_move", nm, 0);
        check("o9_no_ack", ack, -1);
        do_move(1'b1, 4'd2, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("xoot_no_move", nm, 0);
        check("xoot_no_ack", ack, -1);
        check("xoot_no_nack", nack, -1);
        check("xoot_turn", ia.turn, 0);

        // O to cell 0 rejected by GameState
        do_move(1'b0, 4'd0, 3'd4, 1'b0, nm, ack, nack, pl, ps);
        check("oinv_move_cnt", nm, 1);
        check("oinv_nack_lat", nack, RESP_LAT + 2);
        check("oinv_no_ack", ack, -1);
        check("oinv_turn", ia.turn, 0);
        check("oinv_count", ia.move_count, 1);

        // O to 3 with a simultaneous X request that must be ignored
        do_move(1'b0, 4'd3, 3'd0, 1'b1, nm, ack, nack, pl, ps);
        check("o3_move_cnt", nm, 1);
        check("o3_player", pl, 0);
        check("o3_pos", ps, 3);
        check("o3_ack", ack, RESP_LAT + 2);
        check("o3_count", ia.move_count, 2);
        do_move(1'b1, 4'd1, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("x1_count", ia.move_count, 3);
        do_move(1'b0, 4'd4, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("o4_count", ia.move_count, 4);
        do_move(1'b1, 4'd2, 3'd1, 1'b0, nm, ack, nack, pl, ps);
        check("xwin_ack", ack, RESP_LAT + 2);
        check("xwin_game_over", ia.game_over, 1);
        check("xwin_winner", ia.winner, 1);
        check("xwin_count", ia.move_count, 5);
        do_move(1'b1, 4'd5, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("over_x_no_move", nm, 0);
        do_move(1'b0, 4'd6, 3'd0, 1'b0, nm, ack, nack, pl, ps);
        check("over_o_no_move", nm, 0);
        check("over_o_no_ack", ack, -1);

        // Held new_game keeps gs_rst high
        ia.new_game = 1'b1;
        @(negedge clk);
        check("ng_gs_rst1", ia.gs_rst, 1);
        check("ng_game_over", ia.game_over, 0);
        check("ng_winner", ia.winner, 0);
        @(negedge clk);
        check("ng_gs_rst2", ia.gs_rst, 1);
        ia.new_game = 1'b0;
        @(negedge clk);
        check("ng_gs_rst_low", ia.gs_rst, 0);
        check("ng_turn", ia.turn, 1);
        check("ng_count", ia.move_count, 0);

        // Nine running moves end in a draw; cell 8 is the last legal cell
        tot_m = 0; tot_a = 0;
        for (int i = 0; i < 9; i++) begin
            do_move(bit'(i % 2 == 0), 4'(i), 3'd0, 1'b0, nm, ack, nack, pl, ps);
            tot_m += nm;
            if (ack == RESP_LAT + 2) tot_a++;
        end
        check("draw_moves", tot_m, 9);
        check("draw_acks", tot_a, 9);
        check("draw_winner", ia.winner, 3);
        check("draw_game_over", ia.game_over, 1);
        check("draw_count", ia.move_count, 9);

        // Timeout on instance B
        ib.new_game = 1'b1;
        @(negedge clk);
        check("b_gs_rst", ib.gs_rst, 1);
        ib.new_game = 1'b0;
        @(negedge clk);
        check("b_turn_start", ib.turn, 1);
        first_to = -1; n_to = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (ib.timeout) begin
                n_to++;
                if (first_to < 0) first_to = c;
            end
        end
        check("b_timeout_at", first_to, 10);
        check("b_timeout_pulses", n_to, 1);
        check("b_turn_toggled", ib.turn, 0);
        check("b_count_kept", ib.move_count, 0);

        // new_game during WAIT_RESP aborts the pending move
        ib.o_req = 1'b1; ib.o_pos = 4'd4;
        @(negedge clk);
        ib.o_req = 1'b0;
        check("b_issue", ib.gs_move, 1);
        @(negedge clk);
        check("b_wait_busy", ib.busy, 1);
        ib.new_game = 1'b1;
        @(negedge clk);
        ib.new_game = 1'b0;
        check("b_abort_gs_rst", ib.gs_rst, 1);
        n_ack_b = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ib.move_ack) n_ack_b++;
        end
        check("b_abort_no_ack", n_ack_b, 0);
        check("b_abort_turn", ib.turn, 1);
        check("b_abort_count", ib.move_count, 0);

        // Asynchronous reset clears outputs without a clock edge
        check("pre_arst_game_over", ia.game_over, 1);
        rst = 1'b0;
        #1;
        check("arst_game_over", ia.game_over, 0);
        check("arst_winner", ia.winner, 0);
        check("arst_gs_rst", ia.gs_rst, 1);
        check("arst_count", ia.move_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
